// File: rtl/mvm_seq_ctrl_if.sv
// Stream handshakes plus datapath address/control bundle for the mvm_seq_ctrl sequencer.
// master = sequencer side, slave = stream source / datapath / result sink side.
interface mvm_seq_ctrl_if #(
    parameter int M  = 10,
    parameter int N  = 8,
    parameter int AW = $clog2(M*N),
    parameter int XW = $clog2(N),
    parameter int BW = $clog2(M)
);
    logic          s_valid;
    logic          s_ready;
    logic          m_valid;
    logic          m_ready;
    logic          wr_en_x;
    logic [XW-1:0] addr_x;
    logic [AW-1:0] addr_w;
    logic [BW-1:0] addr_b;
    logic          acc_first;
    logic          acc_en;
    logic          relu_en;
    logic [BW-1:0] row_idx;

    modport master (
        input  s_valid, m_ready,
        output s_ready, m_valid, wr_en_x, addr_x, addr_w, addr_b,
               acc_first, acc_en, relu_en, row_idx
    );

    modport slave (
        output s_valid, m_ready,
        input  s_ready, m_valid, wr_en_x, addr_x, addr_w, addr_b,
               acc_first, acc_en, relu_en, row_idx
    );
endinterface

// File: rtl/mvm_seq_ctrl.sv
// Sequencer for a shared matrix-vector MAC datapath: loads an N-word vector, then runs M rows.
// Optional MVM_SEQ_PERF_EN adds stall_cnt / frame_cnt performance counter ports.
module mvm_seq_ctrl #(
    parameter int M  = 10,
    parameter int N  = 8,
    parameter int AW = $clog2(M*N),
    parameter int XW = $clog2(N),
    parameter int BW = $clog2(M)
) (
    input  logic           clk,
    input  logic           reset,
    mvm_seq_ctrl_if.master bus
`ifdef MVM_SEQ_PERF_EN
    ,
    output logic [31:0]    stall_cnt,
    output logic [31:0]    frame_cnt
`endif
);

    typedef enum logic [1:0] {LOAD, RUN, DRAIN, OUT} state_t;

    state_t        state;
    logic [XW-1:0] cnt;
    logic          drain_cnt;
    logic          s_ready;
    logic          m_valid;
    logic [AW-1:0] addr_w;
    logic [BW-1:0] row_idx;
    logic          issue, first;
    logic          issue_d1, first_d1;
    logic          acc_en, acc_first, relu_en;
    logic          accept;

    assign accept        = bus.s_valid && s_ready;
    assign bus.s_ready   = s_ready;
    assign bus.m_valid   = m_valid;
    assign bus.wr_en_x   = accept;
    assign bus.addr_x    = cnt;
    assign bus.addr_w    = addr_w;
    assign bus.addr_b    = row_idx;
    assign bus.row_idx   = row_idx;
    assign bus.acc_en    = acc_en;
    assign bus.acc_first = acc_first;
    assign bus.relu_en   = relu_en;

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values,
    // which is what makes the two-stage issue->acc_en delay line below line up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            cnt       <= '0;
            drain_cnt <= 1'b0;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            addr_w    <= '0;
            row_idx   <= '0;
            issue     <= 1'b0;
            first     <= 1'b0;
            issue_d1  <= 1'b0;
            first_d1  <= 1'b0;
            acc_en    <= 1'b0;
            acc_first <= 1'b0;
            relu_en   <= 1'b0;
        end else begin
            // Read latency (1) plus multiplier register (1) between issue and accumulate.
            issue_d1  <= issue;
            first_d1  <= first;
            acc_en    <= issue_d1;
            acc_first <= first_d1;
            relu_en   <= acc_en && !issue_d1;

            case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        if (cnt == XW'(N-1)) begin
                            s_ready <= 1'b0;
                            cnt     <= '0;
                            issue   <= 1'b1;
                            first   <= 1'b1;
                            state   <= RUN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    first <= 1'b0;
                    if (cnt == XW'(N-1)) begin
                        issue     <= 1'b0;
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        addr_w <= addr_w + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        m_valid <= 1'b0;
                        cnt     <= '0;
                        if (row_idx == BW'(M-1)) begin
                            // Frame done: addr_w wraps here and only here.
                            row_idx <= '0;
                            addr_w  <= '0;
                            s_ready <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            row_idx <= row_idx + 1'b1;
                            addr_w  <= addr_w + 1'b1;
                            issue   <= 1'b1;
                            first   <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef MVM_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            if (state == OUT && !bus.m_ready)
                stall_cnt <= stall_cnt + 32'd1;
            if (state == OUT && bus.m_ready && row_idx == BW'(M-1))
                frame_cnt <= frame_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Directed testbench for mvm_seq_ctrl (M=10, N=8); build with +define+MVM_SEQ_PERF_EN for counters.
module tb_mvm_seq_ctrl;
    localparam int M  = 10;
    localparam int N  = 8;
    localparam int AW = $clog2(M*N);
    localparam int XW = $clog2(N);
    localparam int BW = $clog2(M);
    localparam int SW = 6 + XW + AW + 2*BW;
    localparam int ROWC = N + 3;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   r_cyc = 0;

    mvm_seq_ctrl_if #(.M(M), .N(N)) bus ();

`ifdef MVM_SEQ_PERF_EN
    logic [31:0] stall_cnt, frame_cnt;
`endif

    mvm_seq_ctrl #(.M(M), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MVM_SEQ_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [SW-1:0] snap();
        return {bus.s_ready, bus.m_valid, bus.wr_en_x, bus.acc_first, bus.acc_en, bus.relu_en,
                bus.addr_x, bus.addr_w, bus.addr_b, bus.row_idx};
    endfunction

    // Feeds N words; toggle=1 drives s_valid 1,0,1,... Returns cycle of the Nth accept.
    task automatic load_vector(input bit toggle, output int last);
        int writes = 0;
        int iters  = 0;
        bit v      = 1'b1;
        last = -1;
        while (writes < N && iters < 4*N) begin
            bus.s_valid = toggle ? v : 1'b1;
            #1;
            if (bus.s_ready) begin
                n_cmp++;
                if (bus.addr_x !== XW'(writes)) begin
                    n_err++;
                    $display("FAIL load_addr_x: got %0d want %0d", bus.addr_x, writes);
                end
            end
            if (toggle && !v) begin
                n_cmp++;
                if (bus.wr_en_x !== 1'b0) begin
                    n_err++;
                    $display("FAIL load_gap_write: wr_en_x got %b want 0", bus.wr_en_x);
                end
            end
            if (bus.wr_en_x === 1'b1) begin
                writes++;
                if (writes == N) last = cyc;
            end
            v = ~v;
            iters++;
            tick();
        end
        bus.s_valid = 1'b0;
        n_cmp++;
        if (writes != N) begin
            n_err++;
            $display("FAIL load_count: got %0d writes want %0d", writes, N);
        end
        if (toggle) begin
            n_cmp++;
            if (iters != 2*N-1) begin
                n_err++;
                $display("FAIL load_toggle_span: got %0d cycles want %0d", iters, 2*N-1);
            end
        end
    endtask

    // Checks every cycle of a frame's compute phase against the row timing (m_ready=1).
    task automatic check_compute(input bit sv);
        int r, p, c;
        int row3_sum   = 0;
        int first_hits = 0;
        logic [AW-1:0] aw_d1 = '0;
        logic [AW-1:0] aw_d2 = '0;
        logic [SW-1:0] exp;
        for (int k = 0; k <= M*ROWC; k++) begin
            r = k / ROWC;
            p = k % ROWC;
            c = (p < N) ? p : N-1;
            bus.s_valid = (k < M*ROWC) ? sv : 1'b0;
            bus.m_ready = 1'b1;
            #1;
            if (k == M*ROWC)
                exp = {1'b1, 5'b0, XW'(0), AW'(0), BW'(0), BW'(0)};
            else
                exp = {1'b0, (p == N+2), 1'b0, (p == 2), (p >= 2 && p <= N+1), (p == N+2),
                       XW'(c), AW'(r*N + c), BW'(r), BW'(r)};
            n_cmp++;
            if (snap() !== exp) begin
                n_err++;
                $display("FAIL compute k=%0d: got %h want %h", k, snap(), exp);
            end
            if (k >= 3*ROWC && k < 3*ROWC + N) row3_sum += int'(bus.addr_w);
            if (bus.acc_first === 1'b1 && k >= 3*ROWC && k < 4*ROWC) begin
                first_hits++;
                n_cmp++;
                if (aw_d2 !== AW'(3*N)) begin
                    n_err++;
                    $display("FAIL row3_first_addr: got %0d want %0d", aw_d2, 3*N);
                end
            end
            aw_d2 = aw_d1;
            aw_d1 = bus.addr_w;
            if (k < M*ROWC) tick();
        end
        n_cmp++;
        if (row3_sum != 220) begin
            n_err++;
            $display("FAIL row3_addr_w_sum: got %0d want 220", row3_sum);
        end
        n_cmp++;
        if (first_hits != 1) begin
            n_err++;
            $display("FAIL row3_acc_first_count: got %0d want 1", first_hits);
        end
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (snap() !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", snap());
        end
`ifdef MVM_SEQ_PERF_EN
        n_cmp++;
        if ({stall_cnt, frame_cnt} !== 64'd0) begin
            n_err++;
            $display("FAIL reset_perf: got %0d/%0d want 0/0", stall_cnt, frame_cnt);
        end
`endif
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL sready_before_edge: got %b want 0", bus.s_ready);
        end
        tick();
        n_cmp++;
        if (bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL sready_first_edge: got %b want 1", bus.s_ready);
        end
        r_cyc = cyc;
    endtask

    task automatic test_full_frame();
        int last;
        load_vector(1'b0, last);
        n_cmp++;
        if (last - r_cyc != N-1) begin
            n_err++;
            $display("FAIL load_span: got %0d want %0d", last - r_cyc, N-1);
        end
        check_compute(1'b1);
        n_cmp++;
        if (cyc - r_cyc != N + M*ROWC) begin
            n_err++;
            $display("FAIL frame_span: got %0d want %0d", cyc - r_cyc, N + M*ROWC);
        end
    endtask

    task automatic test_back_to_back();
        int last;
        load_vector(1'b0, last);
        check_compute(1'b1);
`ifdef MVM_SEQ_PERF_EN
        n_cmp++;
        if (frame_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL frame_cnt_b2b: got %0d want 2", frame_cnt);
        end
`endif
    endtask

    task automatic test_stall_toggle();
        int last;
        int mv_rows = 0;
        int it      = 0;
        logic [31:0] s0 = '0;
        load_vector(1'b1, last);
        for (int k = 0; k < N+2; k++) begin
            bus.m_ready = 1'b1;
            bus.s_valid = k[0];
            #1;
            n_cmp++;
            if (bus.wr_en_x !== 1'b0) begin
                n_err++;
                $display("FAIL run_svalid_write: k=%0d wr_en_x got %b want 0", k, bus.wr_en_x);
            end
            tick();
        end
`ifdef MVM_SEQ_PERF_EN
        s0 = stall_cnt;
`endif
        for (int i = 0; i < 5; i++) begin
            bus.m_ready = 1'b0;
            bus.s_valid = 1'b1;
            #1;
            n_cmp++;
            if ({bus.m_valid, bus.s_ready, bus.wr_en_x, bus.acc_en, bus.row_idx, bus.addr_w, bus.addr_x}
                !== {4'b1000, BW'(0), AW'(N-1), XW'(N-1)}) begin
                n_err++;
                $display("FAIL stall_hold i=%0d: mv=%b row=%0d aw=%0d ax=%0d acc_en=%b want mv=1 row=0 aw=%0d ax=%0d acc_en=0",
                         i, bus.m_valid, bus.row_idx, bus.addr_w, bus.addr_x, bus.acc_en, N-1, N-1);
            end
            tick();
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_still_valid: got %b want 1", bus.m_valid);
        end
        tick();
        n_cmp++;
        if ({bus.m_valid, bus.row_idx, bus.addr_w, bus.addr_b, bus.addr_x}
            !== {1'b0, BW'(1), AW'(N), BW'(1), XW'(0)}) begin
            n_err++;
            $display("FAIL stall_release: mv=%b row=%0d aw=%0d ab=%0d want mv=0 row=1 aw=%0d ab=1",
                     bus.m_valid, bus.row_idx, bus.addr_w, bus.addr_b, N);
        end
`ifdef MVM_SEQ_PERF_EN
        n_cmp++;
        if ((stall_cnt - s0) !== 32'd5) begin
            n_err++;
            $display("FAIL stall_cnt_delta: got %0d want 5", stall_cnt - s0);
        end
`endif
        while (bus.s_ready !== 1'b1 && it < 200) begin
            if (bus.m_valid === 1'b1) mv_rows++;
            tick();
            it++;
        end
        n_cmp++;
        if (bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_frame_end: s_ready got %b want 1 within 200 cycles", bus.s_ready);
        end
        n_cmp++;
        if (mv_rows != M-1) begin
            n_err++;
            $display("FAIL stall_rows_left: got %0d want %0d", mv_rows, M-1);
        end
    endtask

    task automatic test_reset_mid_run();
        int last;
        load_vector(1'b0, last);
        bus.m_ready = 1'b1;
        repeat (4*ROWC + 5) tick();
        n_cmp++;
        if ({bus.row_idx, bus.addr_w, bus.addr_x, bus.acc_en} !== {BW'(4), AW'(4*N+5), XW'(5), 1'b1}) begin
            n_err++;
            $display("FAIL mid_position: row=%0d aw=%0d ax=%0d acc_en=%b want row=4 aw=%0d ax=5 acc_en=1",
                     bus.row_idx, bus.addr_w, bus.addr_x, bus.acc_en, 4*N+5);
        end
        reset = 1'b0;
        bus.s_valid = 1'b1;
        #1;
        n_cmp++;
        if (snap() !== '0) begin
            n_err++;
            $display("FAIL reset_async: got %h want 0", snap());
        end
`ifdef MVM_SEQ_PERF_EN
        n_cmp++;
        if (frame_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
        end
`endif
        tick();
        n_cmp++;
        if (snap() !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got %h want 0", snap());
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_sready_return: got %b want 1", bus.s_ready);
        end
        r_cyc = cyc;
        load_vector(1'b0, last);
        check_compute(1'b0);
`ifdef MVM_SEQ_PERF_EN
        n_cmp++;
        if (frame_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL frame_cnt_after_reset: got %0d want 1", frame_cnt);
        end
`endif
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_stall_toggle();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
